// File: rtl/keypad_pkg.sv
// keypad_pkg: shared definitions for the keypad debouncer.
//   kp_state_e : qualification FSM states
//   KEY_MAP    : hex value of each key, KEY_MAP[row_idx][col_idx]
//   one_hot4   : true when exactly one of four bits is set
//   idx4       : one-hot to binary index
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_PRESS_DB   = 2'd1,
    ST_HELD       = 2'd2,
    ST_RELEASE_DB = 2'd3
  } kp_state_e;

  // Nibble [r*4+c] holds the key at row r, column c.
  //   r0: 1 2 3 A   r1: 4 5 6 B   r2: 7 8 9 C   r3: E 0 F D
  localparam logic [3:0][3:0][3:0] KEY_MAP = 64'hDF0E_C987_B654_A321;

  function automatic logic one_hot4(input logic [3:0] v);
    logic res;
    case (v)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: res = 1'b1;
      default:                            res = 1'b0;
    endcase
    return res;
  endfunction

  function automatic logic [1:0] idx4(input logic [3:0] v);
    logic [1:0] res;
    case (v)
      4'b0001: res = 2'd0;
      4'b0010: res = 2'd1;
      4'b0100: res = 2'd2;
      4'b1000: res = 2'd3;
      default: res = 2'd0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/stable_counter.sv
// stable_counter: clear/enable cycle counter with a terminal-count flag.
//   clk, reset : clock, asynchronous active-high reset
//   clear      : synchronous clear to 0 (wins over enable)
//   enable     : advance by one cycle
//   terminal   : count has reached LIMIT-1; the count parks there
module stable_counter #(
  parameter int unsigned LIMIT = 200
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam int unsigned W    = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] count_r;

  // Cycle counter; never wraps because it stops at LAST.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= {W{1'b0}};
    end else if (clear) begin
      count_r <= {W{1'b0}};
    end else if (enable && (count_r != LAST)) begin
      count_r <= count_r + W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign terminal = (count_r == LAST);

endmodule

// File: rtl/keypad_debouncer.sv
// keypad_debouncer: qualifies keypad presses from the synchronized column
// lines and emits one key_valid strobe with key_code per clean press.
//   clk       : scan clock
//   reset     : asynchronous active-high reset
//   sync_col  : synchronized column lines, active-high
//   row       : row currently driven by the scanner, one-hot
//   scan_hold : freeze the scanner while a key is qualified or held
//   key_valid : one-cycle strobe, key_code is a newly accepted key
//   key_code  : hex value of the last accepted key
// Optional feature: define KEYPAD_REPEAT_EN to add auto-repeat strobes every
// REPEAT_CYCLES held cycles.
module keypad_debouncer
  import keypad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 200
`ifdef KEYPAD_REPEAT_EN
  , parameter int unsigned REPEAT_CYCLES = 5000
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] sync_col,
  input  logic [3:0] row,
  output logic       scan_hold,
  output logic       key_valid,
  output logic [3:0] key_code
);

  kp_state_e  state_r, state_s;
  logic [3:0] row_r, col_r;
  logic       candidate_s, match_s, col_bit_s;
  logic       db_clear_s, db_en_s, db_term_s;
  logic       rep_fire_s;
  logic       scan_hold_s, key_valid_s;
  logic [3:0] key_code_s;

  assign candidate_s = one_hot4(row) && one_hot4(sync_col);
  // Exact match: an extra column appearing during press qualification aborts it.
  assign match_s     = (sync_col == col_r);
  // Only the captured column matters once the key is held.
  assign col_bit_s   = |(sync_col & col_r);

  stable_counter #(.LIMIT(DEBOUNCE_CYCLES)) u_db_cnt (
    .clk      (clk),
    .reset    (reset),
    .clear    (db_clear_s),
    .enable   (db_en_s),
    .terminal (db_term_s)
  );

`ifdef KEYPAD_REPEAT_EN
  logic rep_clear_s, rep_term_s;

  // Counts only while staying in HELD, so entry and bounce re-entry start at 0.
  assign rep_clear_s = !((state_r == ST_HELD) && (state_s == ST_HELD)) || rep_term_s;
  assign rep_fire_s  = (state_r == ST_HELD) && col_bit_s && rep_term_s;

  stable_counter #(.LIMIT(REPEAT_CYCLES)) u_rep_cnt (
    .clk      (clk),
    .reset    (reset),
    .clear    (rep_clear_s),
    .enable   (1'b1),
    .terminal (rep_term_s)
  );
`else
  assign rep_fire_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Capture the candidate key when leaving IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_r <= 4'b0000;
      col_r <= 4'b0000;
    end else if ((state_r == ST_IDLE) && candidate_s) begin
      row_r <= row;
      col_r <= sync_col;
    end else begin
      row_r <= row_r;
      col_r <= col_r;
    end
  end

  // Next-state and debounce counter control.
  always_comb begin
    state_s    = state_r;
    db_clear_s = 1'b1;
    db_en_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (candidate_s) begin
          state_s = ST_PRESS_DB;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_PRESS_DB: begin
        if (!match_s) begin
          state_s = ST_IDLE;
        end else if (db_term_s) begin
          state_s = ST_HELD;
        end else begin
          db_clear_s = 1'b0;
          db_en_s    = 1'b1;
        end
      end
      ST_HELD: begin
        if (col_bit_s) begin
          state_s = ST_HELD;
        end else begin
          state_s = ST_RELEASE_DB;
        end
      end
      ST_RELEASE_DB: begin
        if (col_bit_s) begin
          state_s = ST_HELD;
        end else if (db_term_s) begin
          state_s = ST_IDLE;
        end else begin
          db_clear_s = 1'b0;
          db_en_s    = 1'b1;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    scan_hold_s = (state_s != ST_IDLE);
    key_valid_s = ((state_r == ST_PRESS_DB) && match_s && db_term_s) || rep_fire_s;
    if (key_valid_s) begin
      key_code_s = KEY_MAP[idx4(row_r)][idx4(col_r)];
    end else begin
      key_code_s = key_code;
    end
  end

  // Output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_hold <= 1'b0;
      key_valid <= 1'b0;
      key_code  <= 4'h0;
    end else begin
      scan_hold <= scan_hold_s;
      key_valid <= key_valid_s;
      key_code  <= key_code_s;
    end
  end

endmodule

// File: tb/tb_keypad_debouncer.sv
// Scoreboard bench for keypad_debouncer: the stimulus thread runs a run-length
// reference model and queues the expected strobes; a negedge monitor pops and
// compares them whenever the DUT is due to strobe.
module tb_keypad_debouncer;

  localparam int DB = 200;
  localparam int RP = 500;
`ifdef KEYPAD_REPEAT_EN
  localparam bit REP_ON = 1'b1;
`else
  localparam bit REP_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] sync_col = 4'b0000;
  logic [3:0] row = 4'b0000;
  logic       scan_hold, key_valid;
  logic [3:0] key_code;

  keypad_debouncer #(
    .DEBOUNCE_CYCLES(DB)
`ifdef KEYPAD_REPEAT_EN
    , .REPEAT_CYCLES(RP)
`endif
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sync_col  (sync_col),
    .row       (row),
    .scan_hold (scan_hold),
    .key_valid (key_valid),
    .key_code  (key_code)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
  endtask

  // ---------------- reference model ----------------
  logic [3:0] key_tab [4][4] = '{'{4'h1, 4'h2, 4'h3, 4'hA},
                                 '{4'h4, 4'h5, 4'h6, 4'hB},
                                 '{4'h7, 4'h8, 4'h9, 4'hC},
                                 '{4'hE, 4'h0, 4'hF, 4'hD}};

  typedef struct { int cyc; logic [3:0] code; } exp_t;
  exp_t exp_q[$];

  bit         m_engaged, m_accepted, m_releasing;
  int         m_run, m_rel, m_held, m_r, m_c;
  logic       exp_hold = 1'b0;
  logic [3:0] exp_code = 4'h0;

  function automatic void expect_strobe();
    exp_t e;
    e.cyc  = cyc + 1;
    e.code = key_tab[m_r][m_c];
    exp_q.push_back(e);
    exp_code = e.code;
  endfunction

  function automatic void model_clear();
    m_engaged = 1'b0; m_accepted = 1'b0; m_releasing = 1'b0;
    m_run = 0; m_rel = 0; m_held = 0;
    exp_hold = 1'b0;
    exp_code = 4'h0;
    while (exp_q.size() > 0 && exp_q[$].cyc > cyc) void'(exp_q.pop_back());
  endfunction

  // Inputs seen in cycle cyc determine the outputs of cycle cyc+1.
  function automatic void model_advance(input logic [3:0] r, input logic [3:0] c);
    if (!m_engaged) begin
      if ($countones(r) == 1 && $countones(c) == 1) begin
        m_engaged = 1'b1; m_accepted = 1'b0; m_releasing = 1'b0;
        m_r = $clog2(r); m_c = $clog2(c); m_run = 0;
      end
    end else if (!m_accepted) begin
      if (c == (4'b0001 << m_c)) begin
        m_run++;
        if (m_run == DB) begin
          m_accepted = 1'b1; m_held = 0;
          expect_strobe();
        end
      end else begin
        m_engaged = 1'b0;
      end
    end else if (!m_releasing) begin
      if (c[m_c]) begin
        m_held++;
        if (REP_ON && m_held == RP) begin
          expect_strobe();
          m_held = 0;
        end
      end else begin
        m_releasing = 1'b1; m_rel = 0;
      end
    end else begin
      if (c[m_c]) begin
        m_releasing = 1'b0; m_held = 0;
      end else begin
        m_rel++;
        if (m_rel == DB) m_engaged = 1'b0;
      end
    end
    exp_hold = m_engaged;
  endfunction

  // ---------------- monitor ----------------
  int n_strobes = 0;
  int last_strobe = -1;

  always @(negedge clk) begin
    bit due;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) void'(exp_q.pop_front());
    due = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
    if (key_valid) begin
      n_strobes++;
      last_strobe = cyc;
    end
    chk("key_valid", int'(key_valid), int'(due));
    if (due) begin
      chk("strobe_code", int'(key_code), int'(exp_q[0].code));
      void'(exp_q.pop_front());
    end
  end

  // ---------------- stimulus ----------------
  task automatic check_outputs();
    chk("scan_hold", int'(scan_hold), int'(exp_hold));
    chk("key_code", int'(key_code), int'(exp_code));
  endtask

  task automatic step(input logic [3:0] r, input logic [3:0] c);
    @(negedge clk);
    check_outputs();
    row = r;
    sync_col = c;
    model_advance(r, c);
  endtask

  task automatic hold(input logic [3:0] r, input logic [3:0] c, input int n, output int start);
    start = -1;
    for (int i = 0; i < n; i++) begin
      step(r, c);
      if (i == 0) start = cyc;
    end
  endtask

  task automatic do_reset(input int n, input logic [3:0] r, input logic [3:0] c, output int rel);
    @(negedge clk);
    check_outputs();
    #2;
    reset = 1'b1;
    #1;
    chk("reset_scan_hold", int'(scan_hold), 0);
    chk("reset_key_valid", int'(key_valid), 0);
    chk("reset_key_code", int'(key_code), 0);
    model_clear();
    repeat (n) begin
      @(negedge clk);
      check_outputs();
    end
    reset = 1'b0;
    row = r;
    sync_col = c;
    rel = cyc;
    model_advance(r, c);
  endtask

  initial begin
    int t0, t1, tx, s0, rel;
    int kind, len;
    logic [3:0] r, c;

    // Power-on reset.
    model_clear();
    repeat (3) @(negedge clk);
    chk("por_scan_hold", int'(scan_hold), 0);
    chk("por_key_valid", int'(key_valid), 0);
    chk("por_key_code", int'(key_code), 0);
    reset = 1'b0;
    model_advance(4'b0000, 4'b0000);
    hold(4'b0000, 4'b0000, 5, tx);

    // Clean press of key 5.
    s0 = n_strobes;
    hold(4'b0010, 4'b0010, 400, t0);
    chk("clean_hold_high", int'(scan_hold), 1);
    hold(4'b0010, 4'b0000, 260, tx);
    chk("clean_count", n_strobes - s0, 1);
    chk("clean_cycle", last_strobe, t0 + DB + 1);
    chk("clean_code", int'(key_code), 5);
    chk("clean_hold_low", int'(scan_hold), 0);

    // Press bounce on key 3.
    s0 = n_strobes;
    for (int k = 0; k < 6; k++) hold(4'b0001, (k % 2 == 0) ? 4'b0100 : 4'b0000, 25, tx);
    chk("bounce_quiet", n_strobes - s0, 0);
    hold(4'b0001, 4'b0100, 300, t1);
    hold(4'b0001, 4'b0000, 260, tx);
    chk("bounce_count", n_strobes - s0, 1);
    chk("bounce_cycle", last_strobe, t1 + DB + 1);
    chk("bounce_code", int'(key_code), 3);

    // Multi-key: two columns from IDLE, then a second key while held.
    hold(4'b0001, 4'b0011, 50, tx);
    chk("multi_no_capture", int'(scan_hold), 0);
    s0 = n_strobes;
    hold(4'b0100, 4'b0001, 250, t0);
    hold(4'b0100, 4'b0011, 100, tx);
    hold(4'b0100, 4'b0001, 50, tx);
    hold(4'b0100, 4'b0000, 260, tx);
    chk("multi_count", n_strobes - s0, 1);
    chk("multi_code", int'(key_code), 7);
    chk("multi_release", int'(scan_hold), 0);

    // Release bounce on key 0.
    s0 = n_strobes;
    hold(4'b1000, 4'b0010, 250, t0);
    hold(4'b1000, 4'b0000, 50, tx);
    hold(4'b1000, 4'b0010, 50, tx);
    hold(4'b1000, 4'b0000, 200, tx);
    chk("relb_still_hold", int'(scan_hold), 1);
    hold(4'b1000, 4'b0000, 50, tx);
    chk("relb_idle", int'(scan_hold), 0);
    chk("relb_count", n_strobes - s0, 1);
    chk("relb_code", int'(key_code), 0);

    // Reset at press count 100, key 6 held through reset.
    s0 = n_strobes;
    hold(4'b0010, 4'b0100, 101, t0);
    do_reset(3, 4'b0010, 4'b0100, rel);
    hold(4'b0010, 4'b0100, 300, tx);
    chk("rst_count", n_strobes - s0, 1);
    chk("rst_cycle", last_strobe, rel + DB + 1);
    chk("rst_code", int'(key_code), 6);
    hold(4'b0010, 4'b0000, 260, tx);

    // Long hold of key D (auto-repeat when enabled).
    s0 = n_strobes;
    hold(4'b1000, 4'b1000, 1300, t0);
    chk("long_count", n_strobes - s0, REP_ON ? 3 : 1);
    chk("long_last", last_strobe, t0 + (REP_ON ? 2 * RP + DB + 1 : DB + 1));
    chk("long_code", int'(key_code), 13);
    hold(4'b1000, 4'b0000, 260, tx);

    // Randomized segments.
    for (int s = 0; s < 70; s++) begin
      kind = $urandom_range(0, 9);
      r = 4'b0001 << $urandom_range(0, 3);
      c = 4'b0001 << $urandom_range(0, 3);
      if (kind == 0) c = 4'($urandom_range(0, 15));
      if (kind == 1) r = 4'($urandom_range(0, 15));
      len = (kind < 5) ? $urandom_range(1, 60) : $urandom_range(190, 320);
      if (kind == 9) do_reset($urandom_range(1, 3), r, c, rel);
      hold(r, c, len, tx);
      if (kind == 8) hold(r, c | (4'b0001 << $urandom_range(0, 3)), $urandom_range(1, 40), tx);
      hold(r, c & 4'($urandom_range(0, 15)), $urandom_range(0, 240), tx);
    end

    hold(4'b0000, 4'b0000, 300, tx);
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
